// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 interrupt/exception block.
//   CP0 register indices, Status/Cause bit positions, ExcCode values.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  // Status bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;

  // Cause bit positions
  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP_HI  = 15;

  // ExcCode values
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_TEQ     = 5'd13;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer for CP0.
//   Count increments every clock (wrapping), or loads wdata on wr_count.
//   A match is only recognised on a value reached by incrementing, so a
//   load or reset that happens to equal Compare does not raise pending.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr_count          load Count from wdata this cycle
//   wr_compare        load Compare from wdata this cycle, clears pending
//   wdata[31:0]       write data
//   count[31:0]       Count register
//   compare[31:0]     Compare register
//   pending           timer interrupt pending (Cause.IP7)
module cp0_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  logic [31:0] count_inc;
  logic [31:0] compare_nxt;
  logic        hit_q;

  assign count_inc   = count + 32'd1;
  assign compare_nxt = wr_compare ? wdata : compare;

  // hit_q marks "Count just incremented onto Compare"; pending follows one
  // edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      compare <= '0;
      hit_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      count <= wr_count ? wdata : count_inc;
      if (wr_compare)
        compare <= wdata;
      hit_q <= ~wr_count & (count_inc == compare_nxt);
      if (wr_compare)
        pending <= 1'b0;
      else if (hit_q)
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: MIPS-style coprocessor 0 with external interrupts, Count/Compare
//   timer, Status IE/EXL/IM masking and fixed event priority
//   (exception > interrupt > eret > mtc0).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   mfc0/mtc0/eret      current instruction decode
//   exception, cause    synchronous exception and its ExcCode
//   inst_bound          instruction retires; interrupt may be taken
//   pc                  PC saved into EPC on exception/interrupt
//   rd, wdata           CP0 register index and MTC0 data
//   irq                 async external interrupt levels
//   rdata               MFC0 read data (0 when not mfc0)
//   status, epc         Status and EPC registers
//   exc_addr            redirect target: EPC on eret, else vector
//   intr_req            interrupt request
//   int_taken           interrupt entered this cycle
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ     = 5,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'h0040_0004,
  parameter bit          TIMER_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mfc0,
  input  logic               mtc0,
  input  logic               eret,
  input  logic               exception,
  input  logic [4:0]         cause,
  input  logic               inst_bound,
  input  logic [31:0]        pc,
  input  logic [4:0]         rd,
  input  logic [31:0]        wdata,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        rdata,
  output logic [31:0]        status,
  output logic [31:0]        epc,
  output logic [31:0]        exc_addr,
  output logic               intr_req,
  output logic               int_taken
);

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] irq_s;
  logic               ie, exl;
  logic [7:0]         im;
  logic [4:0]         exc_code;
  logic [1:0]         ip_sw;
  logic [7:0]         ip;
  logic [31:0]        cause_val;
  logic [31:0]        count, compare;
  logic               timer_pending;
  logic               do_mtc0;
  logic               wr_count, wr_compare;

  // irq synchronisers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign irq_s = sync_q[SYNC_STAGES-1];

  // IP is live: software bits, synchronised lines, timer pending.
  always_comb begin
    ip              = '0;
    ip[1:0]         = ip_sw;
    ip[2 +: NUM_IRQ] = irq_s;
    ip[7]           = timer_pending;
  end

  assign intr_req  = ie & ~exl & (|(ip & im));
  assign int_taken = intr_req & inst_bound & ~exception;

  // mtc0 only lands when nothing of higher priority happens this cycle.
  assign do_mtc0    = mtc0 & ~exception & ~int_taken & ~eret;
  assign wr_count   = do_mtc0 & (rd == REG_COUNT);
  assign wr_compare = do_mtc0 & (rd == REG_COMPARE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie       <= 1'b0;
      exl      <= 1'b0;
      im       <= '0;
      exc_code <= '0;
      ip_sw    <= '0;
      epc      <= '0;
    end else if (exception) begin
      epc      <= pc;
      exc_code <= cause;
      exl      <= 1'b1;
    end else if (int_taken) begin
      epc      <= pc;
      exc_code <= EXC_INT;
      exl      <= 1'b1;
    end else if (eret) begin
      exl <= 1'b0;
    end else if (do_mtc0) begin
      case (rd)
        REG_STATUS: begin
          ie  <= wdata[ST_IE];
          exl <= wdata[ST_EXL];
          im  <= wdata[ST_IM_HI:ST_IM_LO];
        end
        REG_CAUSE: ip_sw <= wdata[CA_IP_LO+1:CA_IP_LO];
        REG_EPC:   epc   <= wdata;
        default: ;
      endcase
    end
  end

  generate
    if (TIMER_EN) begin : g_timer
      cp0_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_count   (wr_count),
        .wr_compare (wr_compare),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .pending    (timer_pending)
      );
    end else begin : g_no_timer
      assign count         = '0;
      assign compare       = '0;
      assign timer_pending = 1'b0;
    end
  endgenerate

  always_comb begin
    status                    = '0;
    status[ST_IE]             = ie;
    status[ST_EXL]            = exl;
    status[ST_IM_HI:ST_IM_LO] = im;
  end

  always_comb begin
    cause_val                      = '0;
    cause_val[CA_EXC_HI:CA_EXC_LO] = exc_code;
    cause_val[CA_IP_HI:CA_IP_LO]   = ip;
  end

  always_comb begin
    rdata = '0;
    if (mfc0) begin
      case (rd)
        REG_COUNT:   rdata = count;
        REG_COMPARE: rdata = compare;
        REG_STATUS:  rdata = status;
        REG_CAUSE:   rdata = cause_val;
        REG_EPC:     rdata = epc;
        default:     rdata = '0;
      endcase
    end
  end

  assign exc_addr = eret ? epc : EXC_VECTOR;

endmodule

// File: tb/tb_cp0_intc.sv
module tb_cp0_intc;
  import cp0_pkg::*;

  localparam logic [31:0] VEC = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mfc0, mtc0, eret, exception, inst_bound;
  logic [4:0]  cause, rd;
  logic [31:0] pc, wdata;
  logic [4:0]  irq;
  logic [31:0] rdata, status, epc, exc_addr;
  logic        intr_req, int_taken;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_intc dut (
    .clk(clk), .rst_n(rst_n), .mfc0(mfc0), .mtc0(mtc0), .eret(eret),
    .exception(exception), .cause(cause), .inst_bound(inst_bound), .pc(pc),
    .rd(rd), .wdata(wdata), .irq(irq), .rdata(rdata), .status(status),
    .epc(epc), .exc_addr(exc_addr), .intr_req(intr_req), .int_taken(int_taken)
  );

  always #5 clk = ~clk;

  // field order: mtc0, eret, exc, cause, ib, pc, rd, wdata,
  //              exp_status, exp_epc, chk_rd, exp_rd
  typedef struct {
    logic        mtc0;
    logic        eret;
    logic        exc;
    logic [4:0]  cause;
    logic        ib;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] exp_status;
    logic [31:0] exp_epc;
    logic [4:0]  chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    mfc0 = 0; mtc0 = 0; eret = 0; exception = 0; inst_bound = 0;
    cause = 0; rd = 0; pc = 0; wdata = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string name, input logic [4:0] r, input logic [31:0] exp);
    mfc0 = 1; rd = r;
    #1;
    check(name, rdata, exp);
    mfc0 = 0; rd = 0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    idle();
    mtc0 = 1; rd = r; wdata = d;
    step();
    idle();
  endtask

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 0, 0,      12, 32'h0000_0401, 32'h401,  0,      12, 32'h401};
    vecs[1]  = '{1, 0, 0, 0, 0, 0,      12, 32'hFFFF_FFFF, 32'hFF03, 0,      12, 32'hFF03};
    vecs[2]  = '{1, 0, 0, 0, 0, 0,      12, 32'h0,         32'h0,    0,      13, 32'h0};
    vecs[3]  = '{0, 0, 1, 8, 0, 32'h100, 0, 0,             32'h2,    32'h100, 13, 32'h20};
    vecs[4]  = '{0, 1, 0, 0, 0, 0,      0,  0,             32'h0,    32'h100, 14, 32'h100};
    vecs[5]  = '{1, 1, 1, 9, 0, 32'h200, 12, 32'h401,      32'h2,    32'h200, 13, 32'h24};
    vecs[6]  = '{1, 1, 0, 0, 0, 0,      12, 32'h401,       32'h0,    32'h200, 12, 32'h0};
    vecs[7]  = '{1, 0, 0, 0, 0, 0,      13, 32'hFFFF_FFFF, 32'h0,    32'h200, 13, 32'h324};
    vecs[8]  = '{1, 0, 0, 0, 0, 0,      12, 32'h0000_0101, 32'h101,  32'h200, 13, 32'h324};
    vecs[9]  = '{0, 0, 0, 0, 1, 32'h300, 0, 0,             32'h103,  32'h300, 13, 32'h300};
    vecs[10] = '{1, 0, 0, 0, 0, 0,      5,  32'hDEAD,      32'h103,  32'h300, 5,  32'h0};
    vecs[11] = '{1, 0, 0, 0, 0, 0,      13, 32'h0,         32'h103,  32'h300, 13, 32'h0};
    vecs[12] = '{0, 1, 0, 0, 0, 0,      0,  0,             32'h101,  32'h300, 12, 32'h101};
    vecs[13] = '{1, 0, 0, 0, 0, 0,      12, 32'h0,         32'h0,    32'h300, 12, 32'h0};
    vecs[14] = '{0, 0, 0, 0, 1, 32'h999, 0, 0,             32'h0,    32'h300, 14, 32'h300};

    idle();
    irq = '0;
    #12;
    check("rst_status",   status,   32'h0);
    check("rst_epc",      epc,      32'h0);
    check("rst_exc_addr", exc_addr, VEC);
    check("rst_intr_req", {31'b0, intr_req},  32'h0);
    check("rst_int_taken", {31'b0, int_taken}, 32'h0);
    rst_n = 1;

    // table-driven single-cycle operations
    for (int i = 0; i < 15; i++) begin
      idle();
      mtc0 = vecs[i].mtc0; eret = vecs[i].eret; exception = vecs[i].exc;
      cause = vecs[i].cause; inst_bound = vecs[i].ib; pc = vecs[i].pc;
      rd = vecs[i].rd; wdata = vecs[i].wdata;
      step();
      check($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
      check($sformatf("vec%0d_epc", i), epc, vecs[i].exp_epc);
      idle();
      read_chk($sformatf("vec%0d_rdata", i), vecs[i].chk_rd, vecs[i].exp_rd);
    end

    // MFC0 in the same cycle as MTC0 returns the old value
    idle();
    mtc0 = 1; rd = REG_STATUS; wdata = 32'h401; mfc0 = 1;
    #1;
    check("mfc0_old_value", rdata, 32'h0);
    step();
    check("mtc0_status_new", status, 32'h401);
    idle();

    // leave a nonzero ExcCode so interrupt entry has something to clear
    exception = 1; cause = EXC_TEQ; pc = 32'h44;
    step();
    idle(); eret = 1;
    step();
    idle();

    // external irq through the synchroniser
    irq = 5'b00001;
    step();
    check("irq_sync_1clk", {31'b0, intr_req}, 32'h0);
    step();
    check("irq_sync_2clk", {31'b0, intr_req}, 32'h1);
    inst_bound = 1; pc = 32'h0040_0100;
    #1;
    check("int_taken_pulse", {31'b0, int_taken}, 32'h1);
    step();
    check("int_epc", epc, 32'h0040_0100);
    check("int_exl", {31'b0, status[1]}, 32'h1);
    check("int_req_drop", {31'b0, intr_req}, 32'h0);
    check("int_taken_drop", {31'b0, int_taken}, 32'h0);
    idle();
    read_chk("int_cause", REG_CAUSE, 32'h400);
    irq = '0;
    eret = 1;
    step();
    idle();
    step();
    step();

    // timer: Compare=20, Count=10 -> pending 11 clocks later
    wr(REG_STATUS, 32'h8001);
    wr(REG_COMPARE, 32'd20);
    wr(REG_COUNT, 32'd10);
    for (int k = 1; k <= 11; k++) begin
      step();
      check($sformatf("timer_req_k%0d", k), {31'b0, intr_req}, (k == 11) ? 32'h1 : 32'h0);
      if (k == 10) read_chk("timer_count20", REG_COUNT, 32'd20);
    end
    read_chk("timer_ip7_set", REG_CAUSE, 32'h8000);
    wr(REG_COMPARE, 32'd1000);
    check("timer_req_clr", {31'b0, intr_req}, 32'h0);
    read_chk("timer_ip7_clr", REG_CAUSE, 32'h0);

    // Count wrap with Compare=5
    wr(REG_COMPARE, 32'd5);
    wr(REG_COUNT, 32'hFFFF_FFFF);
    read_chk("wrap_max", REG_COUNT, 32'hFFFF_FFFF);
    step();
    read_chk("wrap_zero", REG_COUNT, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      read_chk($sformatf("wrap_no_ip7_%0d", k), REG_CAUSE, 32'h0);
    end
    wr(REG_COMPARE, 32'hFFFF_0000);

    // IE=0: pending interrupt never taken; then SYSCALL and ERET
    wr(REG_STATUS, 32'h400);
    irq = 5'b00001;
    step(); step(); step();
    check("ie0_no_req", {31'b0, intr_req}, 32'h0);
    inst_bound = 1; pc = 32'h777;
    #1;
    check("ie0_no_taken", {31'b0, int_taken}, 32'h0);
    step();
    check("ie0_exl_clear", {31'b0, status[1]}, 32'h0);
    idle();
    exception = 1; cause = EXC_SYSCALL; pc = 32'h500;
    step();
    check("sys_epc", epc, 32'h500);
    check("sys_status", status, 32'h402);
    idle();
    read_chk("sys_cause", REG_CAUSE, 32'h420);
    eret = 1;
    #1;
    check("eret_exc_addr", exc_addr, 32'h500);
    step();
    check("eret_status", status, 32'h400);
    idle();
    #1;
    check("vec_exc_addr", exc_addr, VEC);

    // reset while inside a handler
    exception = 1; cause = EXC_BREAK; pc = 32'h600;
    step();
    idle();
    check("pre_rst_epc", epc, 32'h600);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_status", status, 32'h0);
    check("mid_rst_epc", epc, 32'h0);
    check("mid_rst_exc_addr", exc_addr, VEC);
    check("mid_rst_intr_req", {31'b0, intr_req}, 32'h0);
    read_chk("mid_rst_cause", REG_CAUSE, 32'h0);
    #1;
    rst_n = 1;
    step();
    read_chk("post_rst_count", REG_COUNT, 32'd1);
    check("post_rst_intr_req", {31'b0, intr_req}, 32'h0);
    irq = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
